// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared encodings, defaults, the IF/ID bundle type and the
//               branch-condition helper functions for the IF stage.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // EX-stage jump codes. The code 2'b11 is not produced by the decoder and
    // is treated as "no jump".
    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JALR = 2'b01;
    localparam logic [1:0] JUMP_JAL  = 2'b10;

    // EX-stage branch codes. Codes 3'b101..3'b111 are treated as "no branch".
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // IF/ID pipeline register contents (RV32 widths).
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } ifid_t;

    // True for one of the four real branch codes.
    function automatic logic branch_valid(input logic [2:0] br);
        return (br == BR_BEQ) || (br == BR_BNE) || (br == BR_BLT) || (br == BR_BGE);
    endfunction

    // Branch condition from the ALU flags; the ALU performs rs1 - rs2 for
    // branches, so its sign bit means "less than".
    function automatic logic branch_taken(input logic [2:0] br,
                                          input logic       zero,
                                          input logic       sign);
        logic t;
        t = 1'b0;
        case (br)
            BR_BEQ:  t = zero;
            BR_BNE:  t = !zero;
            BR_BLT:  t = sign;
            BR_BGE:  t = !sign;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Combinational resolution of EX-stage branches and jumps.
//   JumpE, BranchE       : EX-stage control codes
//   ZeroE, ALU_sineE     : ALU flags for the branch comparison
//   PCTargetE            : PC+imm target (jal, branches)
//   ALUResultE           : rs1+imm target (jalr)
//   PCSrcE               : redirect required this cycle
//   PCNextTarget         : redirect address (valid when PCSrcE is high)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      JumpE,
    input  logic [2:0]      BranchE,
    input  logic            ZeroE,
    input  logic            ALU_sineE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCNextTarget
);

    logic w_is_jalr;
    logic w_is_jump;

    always_comb begin
        w_is_jalr    = (JumpE == JUMP_JALR);
        w_is_jump    = w_is_jalr || (JumpE == JUMP_JAL);
        PCSrcE       = w_is_jump || branch_taken(BranchE, ZeroE, ALU_sineE);
        // jalr clears bit 0 of the computed address.
        PCNextTarget = w_is_jalr ? (ALUResultE & ~XLEN'(1)) : PCTargetE;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : IF stage: PC register, next-PC selection, IF/ID register.
//               EX-stage redirects override StallF and squash IF/ID.
//   clk, rst                 : clock, synchronous active-high reset
//   StallF, StallD, FlushD   : hazard-unit controls
//   JumpE, BranchE, ZeroE,
//   ALU_sineE, PCTargetE,
//   ALUResultE               : EX-stage branch/jump resolution inputs
//   InstrAddr, InstrRdata    : instruction memory (combinational read)
//   InstrD, PCD, PCPlus4D    : IF/ID register outputs
//   PCSrcE                   : redirect taken this cycle (to hazard unit)
// Optional    : BRANCH_STATS_EN adds BrCount / BrTakenCount counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic [1:0]      JumpE,
    input  logic [2:0]      BranchE,
    input  logic            ZeroE,
    input  logic            ALU_sineE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] InstrAddr,
    input  logic [31:0]     InstrRdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            PCSrcE
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     BrCount,
    output logic [31:0]     BrTakenCount
`endif
);

    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] w_pcplus4f;
    logic [XLEN-1:0] w_redirect_pc;
    ifid_t           ifid_q, ifid_d;

    branch_resolve #(
        .XLEN(XLEN)
    ) u_branch_resolve (
        .JumpE        (JumpE),
        .BranchE      (BranchE),
        .ZeroE        (ZeroE),
        .ALU_sineE    (ALU_sineE),
        .PCTargetE    (PCTargetE),
        .ALUResultE   (ALUResultE),
        .PCSrcE       (PCSrcE),
        .PCNextTarget (w_redirect_pc)
    );

    always_comb begin
        w_pcplus4f = pcf_q + XLEN'(4);

        // Redirect first: a wrong-path fetch must never be held by StallF.
        pcf_d = w_pcplus4f;
        if (PCSrcE) begin
            pcf_d = w_redirect_pc;
        end else if (StallF) begin
            pcf_d = pcf_q;
        end

        ifid_d = '{instr: InstrRdata, pc: pcf_q, pcplus4: w_pcplus4f};
        if (FlushD || PCSrcE) begin
            ifid_d = '{instr: NOP_INSTR, pc: '0, pcplus4: '0};
        end else if (StallD) begin
            ifid_d = ifid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcf_q  <= RESET_PC;
            ifid_q <= '{instr: NOP_INSTR, pc: '0, pcplus4: '0};
        end else begin
            pcf_q  <= pcf_d;
            ifid_q <= ifid_d;
        end
    end

    assign InstrAddr = pcf_q;
    assign InstrD    = ifid_q.instr;
    assign PCD       = ifid_q.pc;
    assign PCPlus4D  = ifid_q.pcplus4;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] br_taken_count_q, br_taken_count_d;

    // Jumps are not counted; only the four conditional branch codes.
    always_comb begin
        br_count_d       = br_count_q;
        br_taken_count_d = br_taken_count_q;
        if (branch_valid(BranchE)) begin
            br_count_d = br_count_q + 32'd1;
            if (branch_taken(BranchE, ZeroE, ALU_sineE)) begin
                br_taken_count_d = br_taken_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q       <= '0;
            br_taken_count_q <= '0;
        end else begin
            br_count_q       <= br_count_d;
            br_taken_count_q <= br_taken_count_d;
        end
    end

    assign BrCount      = br_count_q;
    assign BrTakenCount = br_taken_count_q;
`endif

endmodule
`default_nettype wire
